// File: rtl/timer_share_ctrl.sv
// Round-robin sequencer that lends one timer_peripheral to NUM_REQ requesters as a one-shot delay.
// It programs the timer over its MMIO port, then waits for expiry or a cancel and reports back.
module timer_share_ctrl #(
  parameter int          NUM_REQ    = 4,
  parameter logic [31:0] TIMER_BASE = 32'h80000020
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [16*NUM_REQ-1:0]   req_psc,
  input  logic [32*NUM_REQ-1:0]   req_arr,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic                    done_expired,
  output logic [31:0]             done_remain,
  output logic                    busy,
  output logic                    m_valid,
  output logic                    m_write,
  output logic [31:0]             m_addr,
  output logic [31:0]             m_wdata,
  output logic [3:0]              m_wstrb,
  input  logic [31:0]             m_rdata,
  input  logic                    m_ready,
  input  logic                    timer_irq
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  localparam logic [31:0] OFF_CR  = 32'h00;
  localparam logic [31:0] OFF_SR  = 32'h04;
  localparam logic [31:0] OFF_PSC = 32'h08;
  localparam logic [31:0] OFF_ARR = 32'h0C;
  localparam logic [31:0] OFF_CNT = 32'h10;

  typedef enum logic [3:0] {
    IDLE, ARB, W_CR0, W_SR0, W_PSC, W_ARR, W_CREN,
    WAIT_IRQ, C_CR0, C_RD, CLR_SR, DONE
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  function automatic bus_t busWrite(input logic [31:0] offset, input logic [31:0] data);
    bus_t b;
    b.valid = 1'b1;
    b.write = 1'b1;
    b.addr  = TIMER_BASE + offset;
    b.wdata = data;
    b.wstrb = 4'hF;
    return b;
  endfunction

  function automatic bus_t busRead(input logic [31:0] offset);
    bus_t b;
    b.valid = 1'b1;
    b.write = 1'b0;
    b.addr  = TIMER_BASE + offset;
    b.wdata = 32'h0;
    b.wstrb = 4'h0;
    return b;
  endfunction

  state_t              state_q;
  bus_t                bus_q;
  logic [IDXW-1:0]     ptr_q;
  logic [IDXW-1:0]     owner_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [15:0]         psc_q;
  logic [31:0]         arr_q;
  logic                expired_q;
  logic [31:0]         remain_q;
  logic                doneExpired_q;
  logic [31:0]         doneRemain_q;

  logic                winFound_d;
  logic [IDXW-1:0]     winIdx_d;

  // Search starts just past the last winner, so a requester that keeps req high goes to the back.
  always_comb begin
    winFound_d = 1'b0;
    winIdx_d   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!winFound_d && req[(int'(ptr_q) + i) % NUM_REQ]) begin
        winFound_d = 1'b1;
        winIdx_d   = IDXW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      bus_q         <= '0;
      ptr_q         <= '0;
      owner_q       <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      psc_q         <= '0;
      arr_q         <= '0;
      expired_q     <= 1'b0;
      remain_q      <= '0;
      doneExpired_q <= 1'b0;
      doneRemain_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) state_q <= ARB;
        end
        ARB: begin
          if (winFound_d) begin
            ptr_q   <= winIdx_d;
            owner_q <= winIdx_d;
            gnt_q   <= ONE_HOT0 << winIdx_d;
            psc_q   <= req_psc[int'(winIdx_d)*16 +: 16];
            arr_q   <= req_arr[int'(winIdx_d)*32 +: 32];
            bus_q   <= busWrite(OFF_CR, 32'h0);
            state_q <= W_CR0;
          end else begin
            state_q <= IDLE;
          end
        end
        W_CR0: if (m_ready) begin
          bus_q   <= busWrite(OFF_SR, 32'h1);
          state_q <= W_SR0;
        end
        W_SR0: if (m_ready) begin
          bus_q   <= busWrite(OFF_PSC, {16'h0, psc_q});
          state_q <= W_PSC;
        end
        W_PSC: if (m_ready) begin
          bus_q   <= busWrite(OFF_ARR, arr_q);
          state_q <= W_ARR;
        end
        W_ARR: if (m_ready) begin
          bus_q   <= busWrite(OFF_CR, 32'h3);
          state_q <= W_CREN;
        end
        W_CREN: if (m_ready) begin
          bus_q   <= '0;
          state_q <= WAIT_IRQ;
        end
        // Expiry wins over a cancel seen in the same cycle; the timer has already stopped.
        WAIT_IRQ: begin
          if (timer_irq) begin
            expired_q <= 1'b1;
            remain_q  <= '0;
            bus_q     <= busWrite(OFF_SR, 32'h1);
            state_q   <= CLR_SR;
          end else if (!req[owner_q]) begin
            bus_q   <= busWrite(OFF_CR, 32'h0);
            state_q <= C_CR0;
          end
        end
        C_CR0: if (m_ready) begin
          bus_q   <= busRead(OFF_CNT);
          state_q <= C_RD;
        end
        C_RD: if (m_ready) begin
          expired_q <= 1'b0;
          remain_q  <= m_rdata;
          bus_q     <= busWrite(OFF_SR, 32'h1);
          state_q   <= CLR_SR;
        end
        CLR_SR: if (m_ready) begin
          bus_q         <= '0;
          done_q        <= gnt_q;
          doneExpired_q <= expired_q;
          doneRemain_q  <= remain_q;
          state_q       <= DONE;
        end
        DONE: begin
          done_q        <= '0;
          doneExpired_q <= 1'b0;
          doneRemain_q  <= '0;
          gnt_q         <= '0;
          state_q       <= (|req) ? ARB : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign done_expired = doneExpired_q;
  assign done_remain  = doneRemain_q;
  assign busy         = (state_q != IDLE);
  assign m_valid      = bus_q.valid;
  assign m_write      = bus_q.write;
  assign m_addr       = bus_q.addr;
  assign m_wdata      = bus_q.wdata;
  assign m_wstrb      = bus_q.wstrb;

endmodule
